// File: rtl/tmds_encode.sv
// DVI 1.0 TMDS encoder for one colour lane: 8-bit pixel or 2-bit control in,
// 10-bit DC-balanced symbol out, three register stages, one symbol per sys_clk.
module tmds_encode (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] data_in,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] data_out
);

  localparam logic [9:0] CTL_00 = 10'h354;
  localparam logic [9:0] CTL_01 = 10'h0AB;
  localparam logic [9:0] CTL_10 = 10'h154;
  localparam logic [9:0] CTL_11 = 10'h2AB;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // ---------------------------------------------------------------- stage 1
  logic [7:0] d_s1;
  logic [3:0] n1d_s1;
  logic       de_s1;
  logic       c0_s1;
  logic       c1_s1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      d_s1   <= 8'h00;
      n1d_s1 <= 4'd0;
      de_s1  <= 1'b0;
      c0_s1  <= 1'b0;
      c1_s1  <= 1'b0;
    end else begin
      d_s1   <= data_in;
      n1d_s1 <= ones8(data_in);
      de_s1  <= de;
      c0_s1  <= c0;
      c1_s1  <= c1;
    end
  end

  // ---------------------------------------------------------------- stage 2
  // XNOR chaining is chosen when it yields fewer transitions.
  logic       xnor_mode;
  logic [8:0] q_m;

  always_comb begin
    xnor_mode = (n1d_s1 > 4'd4) || ((n1d_s1 == 4'd4) && !d_s1[0]);
    q_m       = 9'h000;
    q_m[0]    = d_s1[0];
    for (int i = 1; i < 8; i++) begin
      q_m[i] = xnor_mode ? ~(q_m[i-1] ^ d_s1[i]) : (q_m[i-1] ^ d_s1[i]);
    end
    q_m[8] = ~xnor_mode;
  end

  logic [8:0] q_m_s2;
  logic [3:0] n1q_s2;
  logic [3:0] n0q_s2;
  logic       de_s2;
  logic       c0_s2;
  logic       c1_s2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      q_m_s2 <= 9'h000;
      n1q_s2 <= 4'd0;
      n0q_s2 <= 4'd0;
      de_s2  <= 1'b0;
      c0_s2  <= 1'b0;
      c1_s2  <= 1'b0;
    end else begin
      q_m_s2 <= q_m;
      n1q_s2 <= ones8(q_m[7:0]);
      n0q_s2 <= 4'd8 - ones8(q_m[7:0]);
      de_s2  <= de_s1;
      c0_s2  <= c0_s1;
      c1_s2  <= c1_s1;
    end
  end

  // ---------------------------------------------------------------- stage 3
  // cnt is the running disparity (ones minus zeros) of symbols already sent.
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_nxt;
  logic signed [4:0] n1q_s;
  logic signed [4:0] n0q_s;
  logic [9:0]        sym_nxt;
  logic              q8;

  always_comb begin
    n1q_s   = $signed({1'b0, n1q_s2});
    n0q_s   = $signed({1'b0, n0q_s2});
    q8      = q_m_s2[8];
    sym_nxt = CTL_00;
    cnt_nxt = cnt;
    if (!de_s2) begin
      unique case ({c1_s2, c0_s2})
        2'b00:   sym_nxt = CTL_00;
        2'b01:   sym_nxt = CTL_01;
        2'b10:   sym_nxt = CTL_10;
        default: sym_nxt = CTL_11;
      endcase
      cnt_nxt = 5'sd0;
    end else if ((cnt == 5'sd0) || (n1q_s2 == n0q_s2)) begin
      sym_nxt = {~q8, q8, q8 ? q_m_s2[7:0] : ~q_m_s2[7:0]};
      cnt_nxt = q8 ? (cnt + (n1q_s - n0q_s)) : (cnt + (n0q_s - n1q_s));
    end else if (((cnt > 5'sd0) && (n1q_s2 > n0q_s2)) ||
                 ((cnt < 5'sd0) && (n0q_s2 > n1q_s2))) begin
      // Inverting pulls disparity back toward zero.
      sym_nxt = {1'b1, q8, ~q_m_s2[7:0]};
      cnt_nxt = cnt + (q8 ? 5'sd2 : 5'sd0) + n0q_s - n1q_s;
    end else begin
      sym_nxt = {1'b0, q8, q_m_s2[7:0]};
      cnt_nxt = cnt - (q8 ? 5'sd0 : 5'sd2) + n1q_s - n0q_s;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_out <= 10'h000;
      cnt      <= 5'sd0;
    end else begin
      data_out <= sym_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_encode.sv
// Bench for tmds_encode: hand-computed vector table, mid-stream reset, and a
// long random run against a DVI encoder model plus a decoder round trip.
module tb_tmds_encode;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] data_in;
  logic       c0;
  logic       c1;
  logic       de;
  logic [9:0] data_out;

  tmds_encode dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .data_in  (data_in),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .data_out (data_out)
  );

  // ---------------------------------------------------------------- clock/reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- checks
  task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: data_out=%h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_cnt();
    return int'(dut.cnt);
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic de_i, input logic c1_i, input logic c0_i, input logic [7:0] d_i);
    de      = de_i;
    c1      = c1_i;
    c0      = c0_i;
    data_in = d_i;
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic       de;
    logic       c1;
    logic       c0;
    logic [7:0] data;
    logic [9:0] sym;
    int         cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic set_vec(input int i, input logic de_i, input logic c1_i, input logic c0_i,
                         input logic [7:0] d_i, input logic [9:0] sym_i, input int cnt_i);
    vecs[i].de   = de_i;
    vecs[i].c1   = c1_i;
    vecs[i].c0   = c0_i;
    vecs[i].data = d_i;
    vecs[i].sym  = sym_i;
    vecs[i].cnt  = cnt_i;
  endtask

  // ---------------------------------------------------------------- reference model
  int m_cnt;

  task automatic model_enc(input logic de_i, input logic c1_i, input logic c0_i,
                           input logic [7:0] d, output logic [9:0] sym);
    int   ones;
    int   n1;
    int   n0;
    logic xm;
    logic [8:0] q;
    if (!de_i) begin
      case ({c1_i, c0_i})
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      m_cnt = 0;
    end else begin
      ones = $countones(d);
      xm   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      q    = 9'h000;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xm ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = !xm;
      n1 = $countones(q[7:0]);
      n0 = 8 - n1;
      if (m_cnt == 0 || n1 == n0) begin
        sym   = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        m_cnt = q[8] ? m_cnt + n1 - n0 : m_cnt + n0 - n1;
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
        sym   = {1'b1, q[8], ~q[7:0]};
        m_cnt = m_cnt + 2 * int'(q[8]) + n0 - n1;
      end else begin
        sym   = {1'b0, q[8], q[7:0]};
        m_cnt = m_cnt - 2 * int'(!q[8]) + n1 - n0;
      end
    end
  endtask

  // Returns {de, payload}; payload is pixel byte or {6'b0, c1, c0}.
  function automatic logic [8:0] tmds_decode(input logic [9:0] s);
    logic [7:0] dd;
    logic [7:0] out;
    case (s)
      10'h354: return {1'b0, 8'h00};
      10'h0AB: return {1'b0, 8'h01};
      10'h154: return {1'b0, 8'h02};
      10'h2AB: return {1'b0, 8'h03};
      default: begin
        dd     = s[9] ? ~s[7:0] : s[7:0];
        out    = 8'h00;
        out[0] = dd[0];
        for (int i = 1; i < 8; i++) out[i] = s[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
        return {1'b1, out};
      end
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [9:0] exp_q[$];
  logic [8:0] in_q[$];
  int         cnt_q[$];

  // Two zeroed stages sit ahead of the first real input after reset.
  task automatic reset_model();
    m_cnt = 0;
    exp_q.delete();
    in_q.delete();
    cnt_q.delete();
    repeat (2) begin
      exp_q.push_back(10'h354);
      in_q.push_back(9'h000);
      cnt_q.push_back(0);
    end
  endtask

  // Called at a negedge: drive, let one edge pass, compare at the next negedge.
  task automatic step(input logic de_i, input logic c1_i, input logic c0_i, input logic [7:0] d_i);
    logic [9:0] sym;
    logic [9:0] e_sym;
    logic [8:0] e_in;
    int         e_cnt;
    drive(de_i, c1_i, c0_i, d_i);
    model_enc(de_i, c1_i, c0_i, d_i, sym);
    exp_q.push_back(sym);
    in_q.push_back(de_i ? {1'b1, d_i} : {1'b0, 6'b000000, c1_i, c0_i});
    cnt_q.push_back(m_cnt);
    @(posedge sys_clk);
    @(negedge sys_clk);
    e_sym = exp_q.pop_front();
    e_in  = in_q.pop_front();
    e_cnt = cnt_q.pop_front();
    check_sym("model_sym", data_out, e_sym);
    check_int("model_cnt", dut_cnt(), e_cnt);
    check_sym("roundtrip", {1'b0, tmds_decode(data_out)}, {1'b0, e_in});
    n_vec++;
    if (dut_cnt() < -8 || dut_cnt() > 8) begin
      n_err++;
      $display("FAIL cnt_range: got %0d expected -8..8", dut_cnt());
    end
  endtask

  task automatic step_random();
    logic de_r;
    de_r = ($urandom_range(0, 9) < 7);
    step(de_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    sys_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    //          de    c1    c0    data    sym       cnt
    set_vec( 0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354,  0);
    set_vec( 1, 1'b0, 1'b0, 1'b1, 8'h00, 10'h0AB,  0);
    set_vec( 2, 1'b0, 1'b1, 1'b0, 8'h00, 10'h154,  0);
    set_vec( 3, 1'b0, 1'b1, 1'b1, 8'h00, 10'h2AB,  0);
    set_vec( 4, 1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, -8);
    set_vec( 5, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354,  0);
    set_vec( 6, 1'b1, 1'b0, 1'b0, 8'h00, 10'h100, -8);
    set_vec( 7, 1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF,  2);
    set_vec( 8, 1'b1, 1'b0, 1'b0, 8'h00, 10'h100, -6);
    set_vec( 9, 1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF,  4);
    set_vec(10, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354,  0);
    set_vec(11, 1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, -8);
    set_vec(12, 1'b1, 1'b0, 1'b0, 8'hFF, 10'h0FF, -2);
    set_vec(13, 1'b1, 1'b0, 1'b0, 8'hFF, 10'h0FF,  4);
    set_vec(14, 1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, -4);
    set_vec(15, 1'b1, 1'b0, 1'b0, 8'h01, 10'h1FF,  4);
    set_vec(16, 1'b1, 1'b0, 1'b0, 8'h10, 10'h1F0,  4);
    set_vec(17, 1'b1, 1'b0, 1'b0, 8'h0F, 10'h105,  0);
    set_vec(18, 1'b1, 1'b0, 1'b0, 8'hF0, 10'h205, -4);
    set_vec(19, 1'b0, 1'b1, 1'b1, 8'h00, 10'h2AB,  0);

    repeat (2) @(negedge sys_clk);
    check_sym("reset_sym", data_out, 10'h000);
    check_int("reset_cnt", dut_cnt(), 0);
    sys_rst = 1'b0;
    #1;
    check_sym("release_no_edge", data_out, 10'h000);
    @(negedge sys_clk);

    // Table: output for vector c appears at the negedge after edge c+2.
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) drive(vecs[c].de, vecs[c].c1, vecs[c].c0, vecs[c].data);
      else        drive(1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (c < 2) begin
        check_sym("post_reset_fill", data_out, 10'h354);
        check_int("post_reset_cnt", dut_cnt(), 0);
      end else begin
        check_sym($sformatf("vec%0d_sym", c - 2), data_out, vecs[c-2].sym);
        check_int($sformatf("vec%0d_cnt", c - 2), dut_cnt(), vecs[c-2].cnt);
      end
    end

    // Fresh pipeline for the model-driven runs.
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    reset_model();
    repeat (300) step_random();

    // Asynchronous reset in the middle of a data burst, away from any edge.
    drive(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    #2 sys_rst = 1'b1;
    #1;
    check_sym("midreset_sym", data_out, 10'h000);
    check_int("midreset_cnt", dut_cnt(), 0);
    @(negedge sys_clk);
    check_sym("midreset_hold", data_out, 10'h000);
    sys_rst = 1'b0;
    reset_model();
    repeat (10000) step_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_encode.md
TMDS_ENCODE -- requirements
Module: tmds_encode

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
  sys_clk   in   1   pixel clock; every register is clocked on its rising edge
  sys_rst   in   1   asynchronous, active-high reset
  data_in   in   8   pixel colour byte
  c0        in   1   control bit 0 (HSYNC on the blue lane)
  c1        in   1   control bit 1 (VSYNC on the blue lane)
  de        in   1   data enable: 1 = video period, 0 = control period
  data_out  out  10  TMDS symbol, registered; drives the par_data input of par_to_ser
REQ-002 The block SHALL have no parameters.
REQ-003 There SHALL be no valid/ready handshake: every sys_clk cycle is one pixel, and inputs are sampled on every edge.

Function
REQ-004 The block SHALL be a 3-stage pipeline; inputs sampled at edge N SHALL appear on data_out after edge N+2, a fixed latency of 3 cycles.
REQ-005 Stage 1 SHALL register data_in, n1d (ones count of data_in, 0..8), de, c0 and c1.
REQ-006 Stage 2 SHALL form q_m[8:0] as follows:
  XNOR mode when n1d>4, or when n1d==4 and d[0]==0: q_m[0]=d[0], q_m[i]=q_m[i-1] XNOR d[i] for i=1..7, q_m[8]=0.
  XOR mode otherwise: same chain using XOR, q_m[8]=1.
REQ-007 Stage 2 SHALL register q_m, n1q (ones in q_m[7:0]), n0q = 8-n1q, and the delayed de, c0 and c1.
REQ-008 Stage 3 SHALL keep a running disparity cnt as a 5-bit two's-complement value; the algorithm keeps it within -8..+8 with no wrap.
REQ-009 Stage 3 with delayed de==0 SHALL output a control token, indexed {c1,c0}: 00->10'h354, 01->10'h0AB, 10->10'h154, 11->10'h2AB; cnt SHALL become 0.
REQ-010 Stage 3 with de==1 and (cnt==0 or n1q==n0q) SHALL output data_out={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  cnt SHALL update as cnt+(n1q-n0q) if q_m[8]==1, else cnt+(n0q-n1q).
REQ-011 Stage 3 with de==1 and ((cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q)) SHALL output data_out={1, q_m[8], ~q_m[7:0]}.
  cnt SHALL update as cnt+2*q_m[8]+n0q-n1q.
REQ-012 Stage 3 with de==1 in all other cases SHALL output data_out={0, q_m[8], q_m[7:0]}.
  cnt SHALL update as cnt-2*(~q_m[8])+n1q-n0q.
REQ-013 All cnt arithmetic SHALL be signed and sign-extended to 5 bits; the comparisons cnt>0 and cnt<0 are signed.
REQ-014 Changing de mid-stream SHALL take effect in pipeline order, with no bubble and no extra cycle; the first data symbol after a control period SHALL start from cnt=0.
REQ-015 The block SHALL produce exactly one data_out symbol per sys_clk cycle, with no stalls.

Reset
REQ-016 While sys_rst==1, all pipeline registers SHALL be 0: data_out=10'h000, cnt=0, delayed de/c0/c1=0.
REQ-017 Reset SHALL assert asynchronously and mid-stream; it SHALL discard any in-flight symbols.
REQ-018 After sys_rst deasserts, the first input sampled SHALL appear on data_out after its own 3-cycle latency.
  Until then, data_out SHALL show the reset pipeline contents; the register holding data_out itself stays 10'h000, and zeroed stages behind it produce control token 10'h354 (de=0, c=00).

Verification
REQ-019 Control tokens: de=0 with {c1,c0} = 00, 01, 10, 11 on consecutive cycles -> data_out = 354, 0AB, 154, 2AB (hex) on the 3rd through 6th edges.
REQ-020 Disparity balancing: de=1, data_in=8'h00 held, starting from cnt=0 -> data_out=10'h100 (cnt becomes -8), then 10'h3FF (cnt becomes +2).
REQ-021 XNOR path: de=1, data_in=8'hFF, starting from cnt=0 -> data_out=10'h200 and cnt becomes -8.
REQ-022 Reset mid-stream: assert sys_rst during a random data burst -> data_out=10'h000 and cnt=0 immediately, with no clock edge needed; after release, no stale symbols appear.
REQ-023 Reference model: 10,000 random data_in/de/c0/c1 cycles -> data_out matches a bit-exact DVI 1.0 model delayed 3 cycles, and cnt stays within -8..+8.
REQ-024 Round-trip: 10,000 random cycles into a DVI decoder model -> the decoder recovers data_in, or {c1,c0} during control periods, for every cycle.
